// File: rtl/mips_mult_div_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_mult_div_if
// Summary  : Request/result bundle between execute-stage control and the
//            iterative multiply/divide unit.
// Revision : 1.0
// ============================================================================
interface mips_mult_div_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] rs_data;
   logic [WIDTH-1:0] rt_data;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, rs_data, rt_data,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, rs_data, rt_data,
      output busy, done, hi, lo
   );
endinterface
`default_nettype wire

// File: rtl/mips_mult_div.sv
`default_nettype none
// ============================================================================
// Module   : mips_mult_div
// Summary  : Iterative radix-2 multiply / restoring divide with HI/LO registers.
// Revision : 1.0
// ============================================================================
module mips_mult_div #(
   parameter int WIDTH = 32
) (
   input  wire logic        CLK,
   input  wire logic        reset,
   mips_mult_div_if.slave   bus
);
   localparam int c_CNT_W = $clog2(WIDTH + 1);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_MUL  = 2'd1;
   localparam logic [1:0] c_DIV  = 2'd2;
   localparam logic [1:0] c_FIX  = 2'd3;

   logic [1:0]         r_state;
   logic [c_CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0]   r_b_mag;
   logic [WIDTH-1:0]   r_a_raw;
   logic [2*WIDTH-1:0] r_acc;
   logic               r_is_div;
   logic               r_div_zero;
   logic               r_neg_q;
   logic               r_neg_r;
   logic               r_done;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;

   logic               w_signed;
   logic               w_a_neg;
   logic               w_b_neg;
   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic [WIDTH:0]     w_mul_sum;
   logic [WIDTH:0]     w_div_shift;
   logic [WIDTH:0]     w_div_diff;
   logic               w_div_ok;
   logic [2*WIDTH-1:0] w_prod_fix;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;

   assign w_signed = bus.op[0];
   assign w_a_neg  = w_signed & bus.rs_data[WIDTH-1];
   assign w_b_neg  = w_signed & bus.rt_data[WIDTH-1];
   assign w_a_mag  = w_a_neg ? (~bus.rs_data + 1'b1) : bus.rs_data;
   assign w_b_mag  = w_b_neg ? (~bus.rt_data + 1'b1) : bus.rt_data;

   // Multiply: upper half accumulates, lower half holds the shrinking multiplier.
   assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                    + (r_acc[0] ? {1'b0, r_b_mag} : {(WIDTH+1){1'b0}});

   // Divide: upper half is the partial remainder, lower half dividend/quotient.
   assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
   assign w_div_diff  = w_div_shift - {1'b0, r_b_mag};
   assign w_div_ok    = ~w_div_diff[WIDTH];

   assign w_prod_fix = r_neg_q ? (~r_acc + 1'b1) : r_acc;
   assign w_quo      = r_neg_q ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
   assign w_rem      = r_neg_r ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];

   always_ff @(posedge CLK) begin
      if (reset) begin
         r_state    <= c_IDLE;
         r_cnt      <= '0;
         r_b_mag    <= '0;
         r_a_raw    <= '0;
         r_acc      <= '0;
         r_is_div   <= 1'b0;
         r_div_zero <= 1'b0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_done     <= 1'b0;
         r_hi       <= '0;
         r_lo       <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            c_IDLE: begin
               if (bus.start) begin
                  if (!bus.op[2]) begin
                     r_acc      <= {{WIDTH{1'b0}}, w_a_mag};
                     r_b_mag    <= w_b_mag;
                     r_a_raw    <= bus.rs_data;
                     r_is_div   <= bus.op[1];
                     r_div_zero <= (bus.rt_data == '0);
                     r_neg_q    <= w_a_neg ^ w_b_neg;
                     r_neg_r    <= w_a_neg;
                     r_cnt      <= c_CNT_W'(WIDTH);
                     r_state    <= bus.op[1] ? c_DIV : c_MUL;
                  end else if (bus.op[1:0] == 2'b00) begin
                     r_hi <= bus.rs_data;
                  end else if (bus.op[1:0] == 2'b01) begin
                     r_lo <= bus.rs_data;
                  end
               end
            end
            c_MUL: begin
               r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == c_CNT_W'(1)) r_state <= c_FIX;
            end
            c_DIV: begin
               r_acc <= {(w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0]),
                         r_acc[WIDTH-2:0], w_div_ok};
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == c_CNT_W'(1)) r_state <= c_FIX;
            end
            default: begin
               if (!r_is_div) begin
                  r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                  r_lo <= w_prod_fix[WIDTH-1:0];
               end else if (r_div_zero) begin
                  // Divide by zero returns the untouched dividend, not its magnitude.
                  r_hi <= r_a_raw;
                  r_lo <= '1;
               end else begin
                  r_hi <= w_rem;
                  r_lo <= w_quo;
               end
               r_done  <= 1'b1;
               r_state <= c_IDLE;
            end
         endcase
      end
   end

   assign bus.busy = (r_state != c_IDLE);
   assign bus.done = r_done;
   assign bus.hi   = r_hi;
   assign bus.lo   = r_lo;
endmodule
`default_nettype wire

// File: tb/tb_mips_mult_div.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_mult_div
// Summary  : Directed and random checks of mips_mult_div against a reference model.
// Revision : 1.0
// ============================================================================
module tb_mips_mult_div;
   localparam int W = 32;

   logic CLK = 1'b0;
   logic reset;
   always #5 CLK = ~CLK;

   mips_mult_div_if #(.WIDTH(W)) intf ();

   mips_mult_div #(.WIDTH(W)) dut (
      .CLK   (CLK),
      .reset (reset),
      .bus   (intf)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural result {hi, lo} computed with plain 64-bit arithmetic.
   function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         3'd0: res = 64'(a) * 64'(b);
         3'd1: res = 64'(sa * sb);
         3'd2: res = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
         default: begin
            if (b == 0) res = {a, 32'hFFFF_FFFF};
            else begin
               q   = sa / sb;
               r   = sa % sb;
               res = {r[31:0], q[31:0]};
            end
         end
      endcase
      return res;
   endfunction

   logic [31:0] m_hi, m_lo, p_hi, p_lo;
   int          m_rem   = 0;
   bit          m_done  = 0;
   bit          m_valid = 0;

   always @(posedge CLK) begin
      logic [63:0] res;
      if (reset) begin
         m_hi = 0; m_lo = 0; m_rem = 0; m_done = 0; m_valid = 1;
      end else begin
         m_done = 0;
         if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
               m_hi = p_hi; m_lo = p_lo; m_done = 1;
            end
         end else if (intf.start) begin
            if (intf.op <= 3'd3) begin
               res   = ref_result(intf.op, intf.rs_data, intf.rt_data);
               p_hi  = res[63:32];
               p_lo  = res[31:0];
               m_rem = W + 1;
            end else if (intf.op == 3'd4) m_hi = intf.rs_data;
            else if (intf.op == 3'd5) m_lo = intf.rs_data;
         end
      end
   end

   always @(negedge CLK) begin
      if (m_valid) begin
         check("busy", 64'(intf.busy), 64'(m_rem > 0));
         check("done", 64'(intf.done), 64'(m_done));
         check("hi", 64'(intf.hi), 64'(m_hi));
         check("lo", 64'(intf.lo), 64'(m_lo));
      end
   end

   task automatic wait_done(output int lat, output int bcnt);
      lat = 0; bcnt = 0;
      while (intf.done !== 1'b1 && lat < 100) begin
         if (intf.busy === 1'b1) bcnt++;
         @(negedge CLK);
         lat++;
      end
      check("done_timeout", 64'(lat < 100), 64'(1));
   endtask

   task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int bcnt);
      intf.start = 1'b1; intf.op = o; intf.rs_data = a; intf.rt_data = b;
      @(negedge CLK);
      intf.start = 1'b0; intf.rs_data = $urandom; intf.rt_data = $urandom;
      wait_done(lat, bcnt);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'($urandom_range(0, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   initial begin
      int lat, bcnt, ndone;
      intf.start = 0; intf.op = 0; intf.rs_data = 0; intf.rt_data = 0;
      reset = 1'b1;
      repeat (2) @(negedge CLK);
      reset = 1'b0;
      check("reset_hi", 64'(intf.hi), 64'h0);
      check("reset_lo", 64'(intf.lo), 64'h0);
      check("reset_busy", 64'(intf.busy), 64'h0);

      do_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
      check("multu_latency", 64'(lat), 64'd33);
      check("multu_busy_cycles", 64'(bcnt), 64'd33);
      check("multu_hi", 64'(intf.hi), 64'hFFFF_FFFE);
      check("multu_lo", 64'(intf.lo), 64'h0000_0001);

      // Issued while done is high: accepted back-to-back.
      do_op(3'd1, 32'hFFFF_FFFD, 32'h7, lat, bcnt);
      check("mult_latency", 64'(lat), 64'd33);
      check("mult_hi", 64'(intf.hi), 64'hFFFF_FFFF);
      check("mult_lo", 64'(intf.lo), 64'hFFFF_FFEB);

      do_op(3'd3, 32'hFFFF_FFF9, 32'h2, lat, bcnt);
      check("div_neg_lo", 64'(intf.lo), 64'hFFFF_FFFD);
      check("div_neg_hi", 64'(intf.hi), 64'hFFFF_FFFF);

      do_op(3'd2, 32'd100, 32'd7, lat, bcnt);
      check("divu_lo", 64'(intf.lo), 64'd14);
      check("divu_hi", 64'(intf.hi), 64'd2);

      do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
      check("div_ovf_lo", 64'(intf.lo), 64'h8000_0000);
      check("div_ovf_hi", 64'(intf.hi), 64'h0);

      do_op(3'd2, 32'h1234, 32'h0, lat, bcnt);
      check("div0_latency", 64'(lat), 64'd33);
      check("div0_lo", 64'(intf.lo), 64'hFFFF_FFFF);
      check("div0_hi", 64'(intf.hi), 64'h1234);

      do_op(3'd3, 32'hFFFF_FF00, 32'h0, lat, bcnt);
      check("sdiv0_lo", 64'(intf.lo), 64'hFFFF_FFFF);
      check("sdiv0_hi", 64'(intf.hi), 64'hFFFF_FF00);

      @(negedge CLK);
      intf.start = 1'b1; intf.op = 3'd4; intf.rs_data = 32'hDEAD_BEEF;
      @(negedge CLK);
      check("mthi_hi", 64'(intf.hi), 64'hDEAD_BEEF);
      check("mthi_busy", 64'(intf.busy), 64'h0);
      intf.op = 3'd5; intf.rs_data = 32'h1;
      @(negedge CLK);
      intf.start = 1'b0;
      check("mtlo_lo", 64'(intf.lo), 64'h1);
      check("mtlo_hi", 64'(intf.hi), 64'hDEAD_BEEF);
      check("mtlo_done", 64'(intf.done), 64'h0);

      intf.start = 1'b1; intf.op = 3'd1; intf.rs_data = 32'hFFFF_FFF0; intf.rt_data = 32'd3;
      @(negedge CLK);
      intf.start = 1'b0;
      repeat (4) @(negedge CLK);
      intf.start = 1'b1; intf.op = 3'd5; intf.rs_data = 32'd5;
      @(negedge CLK);
      intf.start = 1'b0;
      wait_done(lat, bcnt);
      check("busy_mtlo_lo", 64'(intf.lo), 64'hFFFF_FFD0);
      check("busy_mtlo_hi", 64'(intf.hi), 64'hFFFF_FFFF);

      @(negedge CLK);
      intf.start = 1'b1; intf.op = 3'd3; intf.rs_data = 32'd1000; intf.rt_data = 32'd3;
      @(negedge CLK);
      intf.start = 1'b0;
      repeat (9) @(negedge CLK);
      reset = 1'b1;
      @(negedge CLK);
      reset = 1'b0;
      check("abort_hi", 64'(intf.hi), 64'h0);
      check("abort_lo", 64'(intf.lo), 64'h0);
      check("abort_busy", 64'(intf.busy), 64'h0);
      check("abort_done", 64'(intf.done), 64'h0);
      ndone = 0;
      repeat (50) begin
         @(negedge CLK);
         if (intf.done === 1'b1) ndone++;
      end
      check("abort_no_done", 64'(ndone), 64'h0);

      for (int i = 0; i < 3000; i++) begin
         intf.start   = ($urandom_range(0, 3) == 0);
         intf.op      = 3'($urandom_range(0, 7));
         intf.rs_data = pick();
         intf.rt_data = pick();
         reset        = ($urandom_range(0, 599) == 0);
         @(negedge CLK);
      end
      intf.start = 1'b0; reset = 1'b0;
      repeat (40) @(negedge CLK);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/mips_mult_div.md
Name: mips_mult_div

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers.
- Sits in the execute stage directly downstream of the register file. Its two operands are the register file's two read-data outputs, DataOut1 (rs) and DataOut2 (rt).
- HI/LO are consumed by MFHI/MFLO, whose results are written back through the register file write port.
- Provides busy/done so the pipeline control can stall dependent MFHI/MFLO.

Parameters:
- WIDTH, 32, operand/HI/LO width. Must be even and at least 4. The iteration count equals WIDTH.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request strobe; sampled on rising edge.
- op  input  3  operation. 000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 110/111 no-op.
- rs_data  input  WIDTH  operand A (multiplicand/dividend/MT source), from register file read port 1.
- rt_data  input  WIDTH  operand B (multiplier/divisor), from register file read port 2.
- busy  output  1  high while a mult/div is in progress.
- done  output  1  one-cycle pulse when HI/LO take a mult/div result.
- hi  output  WIDTH  HI register (product high half / remainder).
- lo  output  WIDTH  LO register (product low half / quotient).

Behaviour:
- Reset (synchronous, CLK edge with reset=1): state=IDLE, hi=0, lo=0, busy=0, done=0, all internal counters/accumulators cleared.
  - Reset has priority over start and aborts any in-flight operation.
  - HI/LO are not partially updated by an aborted operation.
- States: IDLE, MUL, DIV, FIX.
- IDLE, start=1, op=MTHI: hi<=rs_data at that edge; lo unchanged. busy and done stay 0; state stays IDLE.
- IDLE, start=1, op=MTLO: same rule, updating lo instead of hi.
- IDLE, start=1, op=MULT/MULTU/DIV/DIVU (accept edge E0):
  - Operands are latched.
  - For signed ops, the magnitudes |A| and |B| are latched, plus the result sign flags.
  - Counter <= WIDTH; busy<=1; state<=MUL or DIV.
- Operands are captured only at E0; rs_data/rt_data may change afterwards with no effect.
- MUL: radix-2 shift-add, one bit per edge, WIDTH edges, then FIX.
- DIV: restoring shift-subtract, one quotient bit per edge, WIDTH edges, then FIX.
- FIX (one edge):
  - Signed ops apply 2's-complement negation as required.
  - hi/lo are written; done<=1 for exactly the following cycle; busy<=0; state<=IDLE.
- Latency: result is in hi/lo after edge E0+WIDTH+1 (33 for WIDTH=32). busy is high for WIDTH+1 cycles.
- Signed rules:
  - MULT product is negative iff sign(A) XOR sign(B) and the product is nonzero.
  - DIV quotient sign = sign(A) XOR sign(B); remainder sign = sign(A). This gives truncation toward zero.
- Magnitudes are computed in WIDTH-bit unsigned arithmetic. |0x80000000| = 0x80000000.
- DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. No trap.
- Divide by zero (DIV or DIVU, B=0):
  - Same latency as any other divide.
  - Result: lo=all-ones, hi=A as originally presented (unmodified rs_data).
- start while busy=1 is ignored (no queueing, no effect on the in-flight op). This includes MTHI/MTLO.
- start with op 110/111 causes no state change.
- hi/lo hold their value during busy; reads while busy return the previous result. The pipeline stall is the consumer's responsibility.
- start on the same edge that done is high: state is IDLE, so the request is accepted normally. Back-to-back ops therefore need no idle gap.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF:
  - Required: hi=0xFFFFFFFE, lo=0x00000001.
  - done pulses exactly once, 33 cycles after accept.
  - busy is high for 33 cycles.
- MULT -3 x 7 (0xFFFFFFFD, 0x00000007):
  - Required: hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV -7 / 2:
  - Required: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100 / 7:
  - Required: lo=14, hi=2.
- DIV 0x80000000 / 0xFFFFFFFF:
  - Required: lo=0x80000000, hi=0.
- DIVU 0x1234 / 0:
  - Required: lo=0xFFFFFFFF, hi=0x1234.
- MTHI 0xDEADBEEF then MTLO 0x1 on consecutive edges:
  - Required: hi/lo update the next edge after each; busy and done stay 0.
- Start MULT and, while busy, issue MTLO 5:
  - MTLO is ignored; the final result is the product.
- Start DIV, assert reset at cycle 10:
  - Required: hi=lo=0, busy=0, done=0 on the next edge.
  - No later done pulse.
